// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and FIFO entry type for the ALU result stage
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MUL  = 4'b0010,  // unimplemented in the ALU, always flagged as an error
      OP_DIV  = 4'b0011,
      OP_INC  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_DEC  = 4'b0111,
      OP_XOR  = 4'b1000,
      OP_NOT  = 4'b1001,
      OP_SHL  = 4'b1010,
      OP_SHR  = 4'b1011,
      OP_SAR  = 4'b1100,
      OP_SLT  = 4'b1101,
      OP_SLTU = 4'b1110,
      OP_EQ   = 4'b1111
   } opcode_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;
   localparam int FLAG_E = 4;

   typedef struct packed {
      logic [3:0]  opcode;
      logic [4:0]  flags;
      logic [31:0] res;
   } entry_t;

endpackage

// File: rtl/alu_result_buffer_if.sv
// rtl/alu_result_buffer_if.sv - push/pop handshake bundle between ALU, result buffer and consumer
interface alu_result_buffer_if #(
   parameter int DEPTH = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [3:0]               in_opcode;
   logic [31:0]              in_a;
   logic [31:0]              in_b;
   logic [32:0]              in_res;
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_res;
   logic [3:0]               out_opcode;
   logic [4:0]               out_flags;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output in_valid, in_opcode, in_a, in_b, in_res, out_ready,
      input  in_ready, out_valid, out_res, out_opcode, out_flags, count
   );

   modport slave (
      input  in_valid, in_opcode, in_a, in_b, in_res, out_ready,
      output in_ready, out_valid, out_res, out_opcode, out_flags, count
   );
endinterface

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - combinational Z/N/C/V/E derivation and error masking of the ALU result
module alu_flag_gen
   import alu_pkg::*;
(
   input  logic [3:0]  opcode_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [32:0] res_i,
   output logic [31:0] res_o,
   output logic [4:0]  flags_o
);
   logic err;
   logic unused_a_low;

   assign unused_a_low = ^a_i[30:0];

   // On error the ALU result may be undefined, so nothing downstream is allowed to look at it.
   always_comb begin
      err     = (opcode_i == OP_MUL) || ((opcode_i == OP_DIV) && (b_i == '0));
      res_o   = err ? '0 : res_i[31:0];
      flags_o = '0;
      flags_o[FLAG_E] = err;
      flags_o[FLAG_Z] = (res_o == '0);
      if (!err) begin
         flags_o[FLAG_N] = res_o[31];
         case (opcode_i)
            OP_ADD: begin
               flags_o[FLAG_C] = res_i[32];
               flags_o[FLAG_V] = (a_i[31] == b_i[31]) && (res_i[31] != a_i[31]);
            end
            OP_SUB: begin
               flags_o[FLAG_C] = res_i[32];
               flags_o[FLAG_V] = (a_i[31] != b_i[31]) && (res_i[31] != a_i[31]);
            end
            OP_INC, OP_DEC: flags_o[FLAG_C] = res_i[32];
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - registered result FIFO isolating the consumer from ALU combinational timing
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_result_buffer_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t        mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          out_valid_q, out_valid_d;
   logic          in_ready;
   logic          push, pop;
   logic [31:0]   gen_res;
   logic [4:0]    gen_flags;
   entry_t        in_entry;
   entry_t        head;

   alu_flag_gen u_flag_gen (
      .opcode_i (bus.in_opcode),
      .a_i      (bus.in_a),
      .b_i      (bus.in_b),
      .res_i    (bus.in_res),
      .res_o    (gen_res),
      .flags_o  (gen_flags)
   );

   // Readiness depends only on registered occupancy, never on out_ready.
   assign in_ready = (count_q < CW'(DEPTH));

   always_comb begin
      in_entry    = '{opcode: bus.in_opcode, flags: gen_flags, res: gen_res};
      push        = bus.in_valid && in_ready;
      pop         = out_valid_q && bus.out_ready;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      out_valid_d = (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= in_entry;
   end

   // Stale storage is masked while empty so outputs read zero after reset.
   assign head           = out_valid_q ? mem_q[rd_ptr_q] : '0;
   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_res    = head.res;
   assign bus.out_opcode = head.opcode;
   assign bus.out_flags  = head.flags;
   assign bus.count      = count_q;
endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered result stage directly downstream of the 32-bit combinational ALU. Each cycle it can capture one ALU result with its opcode and operands, derive status flags (Z/N/C/V/E) and queue the entry in a small FIFO. The FIFO presents entries to the consumer, such as a register-file writeback or a test harness, through a valid/ready handshake. It is the first clocked point after the ALU and isolates the consumer from ALU combinational timing.

## Interface
- `DEPTH`, default 4, FIFO entries; must be a power of two and at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: upstream entry present; the same signal drives the ALU `en`.
- `in_ready` output 1: buffer can accept an entry this cycle.
- `in_opcode` input 4: opcode applied to the ALU this cycle.
- `in_a` input 32: operand A applied to the ALU.
- `in_b` input 32: operand B applied to the ALU.
- `in_res` input 33: ALU result bus.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: consumer accepts the head entry.
- `out_res` output 32: head result, bits [31:0].
- `out_opcode` output 4: head opcode.
- `out_flags` output 5: head flags, ordered {E,V,C,N,Z} from bit 4 down to bit 0.
- `count` output $clog2(DEPTH)+1: current occupancy.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready` = (count < DEPTH). It is computed from registered state only and has no combinational path from `out_ready`.
- Flags are computed on the push path from the `in_*` signals and stored with the entry.
- **E (error):** set for opcode 0010 (unimplemented) or for opcode 0011 with `in_b`==0. When E=1, the stored result is forced to 0 and C, V, N are 0. Z follows the stored result, so Z=1.
- **Z:** stored res[31:0]==0.
- **N:** stored res[31].
- **C:** in_res[32] for opcodes 0000, 0001, 0100 and 0111; otherwise 0. For 0001, C=1 means borrow.
- **V:** 0 for all opcodes except add and subtract.
  - Opcode 0000: (a[31]==b[31]) && (res[31]!=a[31]).
  - Opcode 0001: (a[31]!=b[31]) && (res[31]!=a[31]).
- Storage is a circular buffer with write and read pointers of width $clog2(DEPTH). Pointers wrap from DEPTH-1 to 0.
- `count` increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
- Simultaneous push and pop:
  - When full, `in_ready`=0, so pop only.
  - When empty, `out_valid`=0, so push only.
  - At any intermediate occupancy, both take effect in the same cycle.
- There is no bypass. An entry pushed into an empty buffer becomes visible one cycle later.
- `out_*` data must be held stable while `out_valid`=1 and `out_ready`=0.

## Timing
- Latency: a push at edge N gives `out_valid`=1 with that entry's data after edge N.
- Throughput: one entry per cycle sustained when `out_ready`=1 continuously.
- Reset, applied at an edge with `rst_n`=0:
  - count=0 and both pointers=0.
  - `out_valid`=0, `in_ready`=1.
  - `out_res`, `out_opcode` and `out_flags` read 0.
  - Storage contents need not be cleared.
- Reset asserted mid-stream discards all entries at that edge. Push and pop requests in that cycle are ignored.
- `out_valid` = (count != 0), driven from a register.
- `out_*` are driven from the head storage entry, gated to 0 while empty.

## Structure
- Shared package `alu_pkg` holds:
  - The opcode constants (OP_ADD=0000 through OP_EQ=1111, plus OP_MUL=0010 marked unimplemented).
  - The flag bit indices FLAG_Z..FLAG_E.
  - A packed entry struct {opcode[3:0], flags[4:0], res[31:0]} of 41 bits.
- One sub-module, `alu_flag_gen`, is combinational. It takes opcode/a/b/res[32:0] and produces {stored res[31:0], flags[4:0]}. The top level holds the FIFO storage, pointers, count and handshake.

## Test plan
- Add: a=0x7FFFFFFF, b=1, res=0x080000000, push then pop. Required out_res=0x80000000, flags V=1, N=1, C=0, Z=0, E=0, one cycle after the push.
- Sub: a=5, b=5, res=0 → Z=1, C=0, V=0. Then a=0, b=1, res=0x1FFFFFFFF → C=1, N=1, V=0.
- Divide by zero: opcode 0011 with b=0, in_res=X → out_res=0, E=1, Z=1, no X on any output. Opcode 0010 likewise gives E=1.
- Fill and stall: 5 consecutive pushes with `out_ready`=0 and DEPTH=4.
  - `in_ready` falls after the 4th push, and the 5th entry is held upstream.
  - Head data stays stable and count=4.
  - Releasing `out_ready` drains the entries in order, then accepts the 5th.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with incrementing `in_a`, wrapping the pointers several times. Count stays at 1 and the output sequence matches the input sequence delayed by one cycle.
- Reset mid-stream: assert `rst_n`=0 with count=3 for one cycle. After that edge, count=0, `out_valid`=0, `in_ready`=1 and outputs=0, and the next push is the first entry seen at the output.
